// File: rtl/decode_window_ctrl_pkg.sv
// Shared types for the decode window sequencer and the back-end stages that consume its records.
package decode_window_ctrl_pkg;

  localparam int unsigned MaxInsBytes = 15;
  localparam int unsigned FetchBytes  = 8;

  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StHalt = 1'b1;

  typedef struct packed {
    logic [63:0]                pc;
    logic [3:0]                 len;
    logic [8*MaxInsBytes-1:0]   bytes;
    logic                       err;
  } ins_rec_t;

endpackage

// File: rtl/decode_window_ctrl_ring.sv
// Circular byte store: 8-byte push at the tail, variable pop at the head, 15-byte peek from the head.
module decode_window_ctrl_ring
  import decode_window_ctrl_pkg::*;
#(
  parameter int unsigned BufBytes = 32,
  localparam int unsigned PtrW    = $clog2(BufBytes),
  localparam int unsigned CntW    = PtrW + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [8*FetchBytes-1:0]   push_data_i,
  input  logic                      pop_i,
  input  logic [3:0]                pop_len_i,
  output logic [CntW-1:0]           count_o,
  output logic [8*MaxInsBytes-1:0]  peek_o
);

  logic [7:0]      mem_q [BufBytes];
  logic [PtrW-1:0] head_q, head_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] tail;

  // A full buffer aliases tail onto head, but no push is allowed then.
  assign tail    = head_q + count_q[PtrW-1:0];
  assign count_o = count_q;

  always_comb begin
    head_d  = head_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) count_d = count_d + CntW'(FetchBytes);
      if (pop_i) begin
        head_d  = head_q + PtrW'(pop_len_i);
        count_d = count_d - CntW'(pop_len_i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      for (int i = 0; i < FetchBytes; i++) begin
        mem_q[tail + PtrW'(i)] <= push_data_i[8*i +: 8];
      end
    end
  end

  // Window byte 0 sits in the top byte, matching the decoder's big-endian indexing.
  always_comb begin
    peek_o = '0;
    for (int i = 0; i < MaxInsBytes; i++) begin
      peek_o[8*(MaxInsBytes-1-i) +: 8] = mem_q[head_q + PtrW'(i)];
    end
  end

endmodule

// File: rtl/decode_window_ctrl.sv
// Decode window sequencer: feeds the decoder a 15-byte window, registers one record per cycle.
module decode_window_ctrl
  import decode_window_ctrl_pkg::*;
#(
  parameter int unsigned BufBytes = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          fetch_valid_i,
  output logic          fetch_ready_o,
  input  logic [63:0]   fetch_data_i,
  input  logic          redirect_valid_i,
  input  logic [63:0]   redirect_pc_i,
  output logic [119:0]  dec_window_o,
  output logic [63:0]   dec_pc_o,
  output logic          dec_go_o,
  input  logic [3:0]    dec_len_i,
  input  logic          dec_err_i,
  output logic          ins_valid_o,
  input  logic          ins_ready_i,
  output logic [63:0]   ins_pc_o,
  output logic [3:0]    ins_len_o,
  output logic [119:0]  ins_bytes_o,
  output logic          ins_err_o
);

  localparam int unsigned CntW = $clog2(BufBytes) + 1;

  logic [0:0]      state_q, state_d;
  logic [63:0]     cur_pc_q, cur_pc_d;
  logic            ins_valid_q, ins_valid_d;
  ins_rec_t        ins_q, ins_d;
  logic [CntW-1:0] count;
  logic            dec_ok, dec_bad, push;
  logic [3:0]      pop_len;
  logic [CntW:0]   fill_need, fill_room;

  assign dec_go_o = (state_q == StRun) && (count >= CntW'(MaxInsBytes)) &&
                    (!ins_valid_q || ins_ready_i) && !redirect_valid_i;
  assign dec_ok   = dec_go_o && !dec_err_i && (dec_len_i != 4'd0);
  assign dec_bad  = dec_go_o && !dec_ok;
  assign pop_len  = dec_ok ? dec_len_i : 4'd0;

  // Space freed by this cycle's pop counts toward accepting a beat.
  assign fill_need     = {1'b0, count} + (CntW+1)'(FetchBytes);
  assign fill_room     = (CntW+1)'(BufBytes) + (CntW+1)'(pop_len);
  assign fetch_ready_o = !rst_i && (state_q == StRun) && !redirect_valid_i &&
                         (fill_need <= fill_room);
  assign push          = fetch_valid_i && fetch_ready_o;

  assign dec_pc_o    = cur_pc_q;
  assign ins_valid_o = ins_valid_q;
  assign ins_pc_o    = ins_q.pc;
  assign ins_len_o   = ins_q.len;
  assign ins_bytes_o = ins_q.bytes;
  assign ins_err_o   = ins_q.err;

  decode_window_ctrl_ring #(
    .BufBytes(BufBytes)
  ) u_ring (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_valid_i),
    .push_i      (push),
    .push_data_i (fetch_data_i),
    .pop_i       (dec_ok),
    .pop_len_i   (dec_len_i),
    .count_o     (count),
    .peek_o      (dec_window_o)
  );

  always_comb begin
    state_d     = state_q;
    cur_pc_d    = cur_pc_q;
    ins_valid_d = ins_valid_q;
    ins_d       = ins_q;
    if (redirect_valid_i) begin
      state_d     = StRun;
      cur_pc_d    = redirect_pc_i;
      ins_valid_d = 1'b0;
    end else if (dec_ok) begin
      ins_d.pc    = cur_pc_q;
      ins_d.len   = dec_len_i;
      ins_d.bytes = dec_window_o;
      ins_d.err   = 1'b0;
      ins_valid_d = 1'b1;
      cur_pc_d    = cur_pc_q + 64'(dec_len_i);
    end else if (dec_bad) begin
      ins_d.pc    = cur_pc_q;
      ins_d.len   = 4'd0;
      ins_d.bytes = dec_window_o;
      ins_d.err   = 1'b1;
      ins_valid_d = 1'b1;
      state_d     = StHalt;
    end else if (ins_ready_i) begin
      ins_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      cur_pc_q    <= '0;
      ins_valid_q <= 1'b0;
      ins_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_pc_q    <= cur_pc_d;
      ins_valid_q <= ins_valid_d;
      ins_q       <= ins_d;
    end
  end

endmodule

// File: doc/decode_window_ctrl.md
Name: decode_window_ctrl

Overview:
- Sequencer in front of the operand/opcode decoder. Collects 8-byte fetch beats into a byte window buffer and presents the oldest 15 bytes, with their PC, to the combinational decoder.
- Consumes the instruction length the decoder returns, registers one decoded-instruction record per cycle for the back end, and advances the window.
- Handles decoder error halt and PC redirect flush.

Parameters:
- BUF_BYTES, 32, window buffer capacity in bytes; power of two, ≥ 2*FETCH_BYTES.
- FETCH_BYTES, 8, bytes per fetch beat.
- MAX_INS_BYTES, 15, maximum x86-64 instruction length; the decode window width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- fetch_valid  in  1  fetch beat present
- fetch_ready  out  1  buffer can accept a beat this cycle
- fetch_data  in  64  beat bytes; byte 0 in [7:0], lowest address first
- redirect_valid  in  1  flush and restart at redirect_pc
- redirect_pc  in  64  new decode PC
- dec_window  out  120  oldest 15 buffered bytes; byte 0 in [119:112], matching the decoder's big-endian opd_bytes indexing
- dec_pc  out  64  PC of dec_window byte 0
- dec_go  out  1  window valid and the decoder result will be consumed this cycle
- dec_len  in  4  instruction length from decoder (prefix+opcode+operand bytes)
- dec_err  in  1  decoder returned -1
- ins_valid  out  1  registered instruction record valid
- ins_ready  in  1  back end accepts record
- ins_pc  out  64  PC of instruction
- ins_len  out  4  length in bytes
- ins_bytes  out  120  raw window, unconsumed tail bytes included
- ins_err  out  1  record is an error marker; decode halted

Behaviour:
- Storage: circular byte array of BUF_BYTES, head pointer, count register of $clog2(BUF_BYTES)+1 bits, and cur_pc of 64 bits.
- Reset, asynchronous: count=0, head=0, cur_pc=0, state=RUN, ins_valid=0, ins_err=0, ins_pc/ins_len/ins_bytes=0, fetch_ready=0 while reset is asserted.
- fetch_ready = (state==RUN) && !redirect_valid && (count + FETCH_BYTES - pop_len ≤ BUF_BYTES). pop_len is the bytes consumed this cycle, so a simultaneous pop frees space.
- Push: on fetch_valid && fetch_ready, write 8 bytes at (head+count) mod BUF_BYTES.
- dec_go = (state==RUN) && count ≥ MAX_INS_BYTES && (!ins_valid || ins_ready) && !redirect_valid.
- A window is presented only when all 15 bytes are resident, so the decoder never reads stale bytes.
- On dec_go with !dec_err && dec_len ≠ 0:
  - Load the output register: ins_pc=cur_pc, ins_len=dec_len, ins_bytes=dec_window, ins_err=0, ins_valid=1.
  - head += dec_len (mod BUF_BYTES), cur_pc += dec_len, pop_len=dec_len.
- Latency: window byte resident to ins_valid is one cycle. Throughput is one instruction per cycle while count stays ≥ 15.
- Simultaneous push and pop: count_next = count + 8 − dec_len. Wrap of head and tail is modulo BUF_BYTES.
- Error: if dec_go && (dec_err || dec_len==0):
  - Emit a record with ins_err=1, ins_pc=cur_pc, ins_len=0.
  - Go to HALT. No pop, no further fetch accept, dec_go=0.
- ins_valid clears on ins_ready unless a new record loads in the same cycle.
- States:
  - RUN → HALT on error.
  - HALT → RUN only on redirect_valid.
  - Any state → RUN on redirect_valid.
- Redirect takes priority over everything in the same cycle:
  - count=0, head=0, cur_pc=redirect_pc, ins_valid=0.
  - The fetch beat that cycle is dropped (fetch_ready=0).
  - The decoder result that cycle is ignored.
- Reset mid-operation discards all buffered bytes and the pending record.
- Underflow cannot occur: pop happens only when count ≥ 15 ≥ dec_len.
- Overflow is prevented by the fetch_ready term. A beat offered while fetch_ready=0 is held by fetch, not lost.

Decomposition:
- DecoderTypes gets:
  - localparams MAX_INS_BYTES and FETCH_BYTES.
  - a packed struct ins_rec_t {pc, len, bytes, err} used for the output register and by downstream stages.
- One sub-module, byte_ring_buffer: circular byte storage with push-8, pop-N and 15-byte peek. The controller keeps the FSM, PC and output register.

Test Plan:
- Reset, then stream beats 0x00..0x1F from redirect_pc=0x400000; decoder returns len=3 repeatedly → ins_pc 0x400000, 0x400003, 0x400006…; first ins_valid occurs 1 cycle after count first reaches ≥15.
- Hold ins_ready=0 with count=32 → fetch_ready=0, dec_go=0, record stable. Release → one pop per cycle; fetch resumes once count + 8 − len ≤ 32.
- Push and pop in the same cycle with count=16, len=8 → count stays 16; head wraps past byte 31 and dec_window shows the correct wrapped bytes.
- dec_err=1 at pc 0x400010 → a record with ins_err=1, ins_len=0; HALT; fetch_ready=0. redirect_pc=0x500000 → count=0, RUN, next record pc 0x500000.
- redirect_valid in the same cycle as fetch_valid and dec_go → beat dropped, no record emitted, cur_pc=redirect_pc.
- Assert reset for 1 cycle mid-stream with ins_valid=1 → ins_valid=0 immediately (asynchronous), count=0, fetch_ready=0 until reset deasserts.
